// File: rtl/pixel_write_buffer.sv
// Pixel capture front end: frame-aligned sampling into a FWFT FIFO of {pixel, address} entries.
// Latency 2 edges from accept to out_valid; a full FIFO with no pop drops the entry and resyncs to (0,0).

module pwb_fifo #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic                  wr_rdy,
  output logic                  rd_vld,
  output logic [WIDTH-1:0]      rd_dat,
  input  logic                  rd_rdy,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full   = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign rd_vld = (level != '0);
  assign pop    = rd_vld && rd_rdy;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_rdy = !full || pop;
  assign push   = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module pixel_write_buffer #(
  parameter int PRECISION  = 11,
  parameter int PIXEL_SIZE = 16,
  parameter int X_RES      = 800,
  parameter int Y_RES      = 600,
  parameter int ADDR_WIDTH = 20,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  hw_pixel_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [PIXEL_SIZE-1:0] in_data,
  input  logic [PRECISION-1:0]  in_x,
  input  logic [PRECISION-1:0]  in_y,
  output logic                  out_valid,
  output logic [PIXEL_SIZE-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  input  logic                  out_ready,
  output logic                  frame_start,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [DEPTH_LOG2:0]   level
);
  localparam logic [31:0] X_LIM = X_RES;
  localparam logic [31:0] Y_LIM = Y_RES;

  typedef struct packed {
    logic [PIXEL_SIZE-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
  } pix_t;

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  qualified;
  logic                  origin;
  logic                  capture;
  logic                  drop;
  logic                  s1_vld;
  pix_t                  s1_dat;
  logic                  wr_rdy;
  pix_t                  head_dat;
  logic [ADDR_WIDTH-1:0] addr;

  assign qualified = in_valid && (32'(in_x) < X_LIM) && (32'(in_y) < Y_LIM);
  assign origin    = (in_x == '0) && (in_y == '0);
  assign addr      = ADDR_WIDTH'(in_y) * ADDR_WIDTH'(X_RES) + ADDR_WIDTH'(in_x);
  assign drop      = s1_vld && !wr_rdy;

  // A (0,0) sample always wins, even on the edge that drops the previous entry.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      SYNC: begin
        if (qualified && origin) begin
          capture   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (qualified && origin) begin
          capture = 1'b1;
        end else if (drop) begin
          state_nxt = SYNC;
        end else if (qualified) begin
          capture = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (capture) begin
      s1_dat.data <= in_data;
      s1_dat.addr <= addr;
    end
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      s1_vld      <= capture;
      frame_start <= capture && origin;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  pwb_fifo #(
    .WIDTH      ($bits(pix_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk    (hw_pixel_clk),
    .rst    (rst),
    .wr_vld (s1_vld),
    .wr_dat (s1_dat),
    .wr_rdy (wr_rdy),
    .rd_vld (out_valid),
    .rd_dat (head_dat),
    .rd_rdy (out_ready),
    .level  (level)
  );

  assign out_data = head_dat.data;
  assign out_addr = head_dat.addr;
endmodule

// File: tb/tb_pixel_write_buffer.sv
// Bench for pixel_write_buffer: vector table for capture/qualification, hand sequences for
// overflow, full-throughput and reset; popped entries are checked against a scoreboard queue.

module tb_pixel_write_buffer;
  localparam int PR = 11;
  localparam int PS = 16;
  localparam int AW = 20;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [PS-1:0] in_data = '0;
  logic [PR-1:0] in_x = '0;
  logic [PR-1:0] in_y = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [PS-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          frame_start;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [DL:0]   level;

  always #5 clk = ~clk;

  pixel_write_buffer #(
    .PRECISION  (PR),
    .PIXEL_SIZE (PS),
    .X_RES      (800),
    .Y_RES      (600),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .hw_pixel_clk (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_x         (in_x),
    .in_y         (in_y),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_ready    (out_ready),
    .frame_start  (frame_start),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .level        (level)
  );

  typedef struct packed {
    logic [PS-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    logic          v;
    int            x;
    int            y;
    logic [PS-1:0] d;
    bit            cap;
    bit            fs;
    logic [AW-1:0] addr;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted output beat must match the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got data 0x%0h addr %0d, expected no entry", out_data, out_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_data", 32'(out_data), 32'(mon_e.data));
        chk("pop_addr", 32'(out_addr), 32'(mon_e.addr));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pa(input int x, input int y);
    return AW'(y * 800 + x);
  endfunction

  task automatic expect_entry(input logic [PS-1:0] d, input logic [AW-1:0] a);
    exp_t e;
    e.data = d;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic send(input int x, input int y, input logic [PS-1:0] d, input bit cap);
    in_valid = 1'b1;
    in_x     = PR'(x);
    in_y     = PR'(y);
    in_data  = d;
    if (cap) expect_entry(d, pa(x, y));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) tick();
    chk({name, "_queue_left"}, sb.size(), 0);
    chk({name, "_level"}, 32'(level), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vt[10];
  bit   prev;

  initial begin
    vt[0] = '{1'b1,    5,    0, 16'h0001, 1'b0, 1'b0, 20'd0};
    vt[1] = '{1'b1,    0,    0, 16'h0002, 1'b1, 1'b1, 20'd0};
    vt[2] = '{1'b1,    1,    0, 16'h0003, 1'b1, 1'b0, 20'd1};
    vt[3] = '{1'b1,   10,    3, 16'hABCD, 1'b1, 1'b0, 20'd2410};
    vt[4] = '{1'b1,  800,    0, 16'h0004, 1'b0, 1'b0, 20'd0};
    vt[5] = '{1'b1,    0,  600, 16'h0005, 1'b0, 1'b0, 20'd0};
    vt[6] = '{1'b0,    3,    3, 16'h0006, 1'b0, 1'b0, 20'd0};
    vt[7] = '{1'b1,  799,  599, 16'h0007, 1'b1, 1'b0, 20'd479999};
    vt[8] = '{1'b1,    0,    0, 16'h0008, 1'b1, 1'b1, 20'd0};
    vt[9] = '{1'b1, 2047, 2047, 16'h0009, 1'b0, 1'b0, 20'd0};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_count", 32'(drop_count), 0);

    // Qualification, sync, address and 2-edge latency with a free-running sink.
    out_ready = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = vt[i].v;
      in_x     = PR'(vt[i].x);
      in_y     = PR'(vt[i].y);
      in_data  = vt[i].d;
      if (vt[i].cap) expect_entry(vt[i].d, vt[i].addr);
      tick();
      chk($sformatf("vec%0d_frame_start", i), 32'(frame_start), 32'(vt[i].fs));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(prev));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(prev));
      prev = vt[i].cap;
    end
    drain("vec_drain");

    // 17 pixels into a stalled sink: 16 fill, the 17th is dropped, FSM resyncs.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(i, 0, 16'(16'h100 + i), i < 16);
    chk("fill_level", 32'(level), 16);
    tick();
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop_count", 32'(drop_count), 1);
    chk("ovf_level", 32'(level), 16);
    chk("stall_head_data", 32'(out_data), 32'h100);
    chk("stall_head_addr", 32'(out_addr), 0);
    send(5, 0, 16'h0555, 1'b0);
    tick();
    chk("sync_discard_drop_count", 32'(drop_count), 1);
    chk("sync_discard_level", 32'(level), 16);
    drain("ovf_drain");

    // (0,0) on the very edge of a drop is still captured and restarts the frame.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(i, 0, 16'(16'h200 + i), i < 16);
    send(0, 0, 16'hBEEF, 1'b1);
    chk("drop_origin_frame_start", 32'(frame_start), 1);
    chk("drop_origin_drop_count", 32'(drop_count), 2);
    out_ready = 1'b1;
    tick();
    chk("drop_origin_level", 32'(level), 16);
    drain("drop_origin_drain");

    // Full FIFO with a continuous stream and sink: push and pop every edge.
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      out_ready = (i >= 17);
      send(i, 0, 16'(16'h300 + i), 1'b1);
      if (i >= 17) chk($sformatf("full_tput_level_%0d", i), 32'(level), 16);
    end
    chk("full_tput_drop_count", 32'(drop_count), 2);
    drain("full_tput_drain");

    // Mid-stream reset with 8 queued and one in flight, then resync on (0,0).
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i, 0, 16'(16'h400 + i), 1'b1);
    tick();
    chk("pre_rst_level", 32'(level), 8);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_x     = PR'(8);
    in_y     = '0;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_drop_count", 32'(drop_count), 0);
    out_ready = 1'b1;
    send(1, 0, 16'h0501, 1'b0);
    chk("post_rst_x1_level", 32'(level), 0);
    send(2, 0, 16'h0502, 1'b0);
    chk("post_rst_x2_out_valid", 32'(out_valid), 0);
    send(0, 0, 16'h5A5A, 1'b1);
    chk("post_rst_origin_frame_start", 32'(frame_start), 1);
    chk("post_rst_origin_out_valid_n", 32'(out_valid), 0);
    tick();
    chk("post_rst_origin_out_valid_n1", 32'(out_valid), 1);
    chk("post_rst_origin_frame_start_low", 32'(frame_start), 0);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
